// File: rtl/ring_mon_pkg.sv
// Shared types for the ring phase monitor: FSM states and fault reason codes.
// Pure declarations; no logic, no latency, no flow control.
package ring_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_STEP   = 2'b10;

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot check and binary index of the set bit of a ring word.
// Zero latency, no flow control; index is meaningless when is_onehot is low.
module onehot_encoder
  import ring_mon_pkg::*;
#(
  parameter int N    = 4,
  parameter int PH_W = $clog2(N)
) (
  input  logic [N-1:0]    q,
  output logic [PH_W-1:0] index,
  output logic            is_onehot
);

  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i]) begin
        index = index | PH_W'(i);
      end
    end
  end

  // Non-zero with no second bit set: clearing the lowest set bit leaves nothing.
  assign is_onehot = (q != '0) && ((q & (q - N'(1))) == '0);

endmodule

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot rotating ring for legal single-step rotation, reports phase and revolutions, latches faults.
// All outputs registered, one cycle after ring_q is sampled; no backpressure, reload requested via reload_req.
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int N           = 4,
  parameter int PH_W        = $clog2(N),
  parameter int REV_W       = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     ring_q,
  input  logic             ring_select,
  input  logic             err_clr,
  output logic [PH_W-1:0]  phase,
  output logic             phase_valid,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_count,
  output logic             err_sticky,
  output logic [1:0]       err_code,
  output logic             reload_req
);

  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  state_t            state;
  logic [N-1:0]      prev_q;
  logic [LC_W-1:0]   lock_cnt;
  logic [LC_W-1:0]   lock_nxt;
  logic [N-1:0]      rot_prev;
  logic [PH_W-1:0]   enc_index;
  logic              is_onehot;
  logic              good_step;
  logic              wrap;
  logic              fault_det;
  logic [1:0]        fault_code;

  onehot_encoder #(
    .N    (N),
    .PH_W (PH_W)
  ) u_enc (
    .q         (ring_q),
    .index     (enc_index),
    .is_onehot (is_onehot)
  );

  assign rot_prev   = {prev_q[N-2:0], prev_q[N-1]};
  assign good_step  = is_onehot && (ring_q == rot_prev);
  assign wrap       = prev_q[N-1] && (ring_q == N'(1));
  assign lock_nxt   = lock_cnt + LC_W'(1);
  // A deliberate reload (ring_select low) is never a fault.
  assign fault_det  = (state == TRACK) && ring_select && !good_step;
  assign fault_code = is_onehot ? ERR_STEP : ERR_ONEHOT;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      prev_q      <= '0;
      lock_cnt    <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      rev_tick    <= 1'b0;
      rev_count   <= '0;
      err_sticky  <= 1'b0;
      err_code    <= ERR_NONE;
      reload_req  <= 1'b0;
    end else begin
      prev_q   <= ring_q;
      rev_tick <= 1'b0;

      case (state)
        IDLE: begin
          if (ring_select && is_onehot) begin
            state    <= LOCK;
            lock_cnt <= '0;
          end
        end

        LOCK: begin
          if (!ring_select) begin
            state <= IDLE;
          end else if (good_step) begin
            lock_cnt <= lock_nxt;
            if (lock_nxt == LC_W'(LOCK_CYCLES)) begin
              state       <= TRACK;
              phase_valid <= 1'b1;
              phase       <= enc_index;
            end
          end else begin
            state <= IDLE;
          end
        end

        TRACK: begin
          if (wrap) begin
            rev_tick  <= 1'b1;
            rev_count <= rev_count + REV_W'(1);
          end
          if (!ring_select) begin
            state       <= IDLE;
            phase_valid <= 1'b0;
          end else if (good_step) begin
            phase <= enc_index;
          end else begin
            state       <= FAULT;
            phase_valid <= 1'b0;
            reload_req  <= 1'b1;
          end
        end

        FAULT: begin
          if (!ring_select) begin
            state      <= IDLE;
            reload_req <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase

      // First fault wins while sticky; a fault on the clearing edge re-arms with the new code.
      if (fault_det) begin
        if (!err_sticky || err_clr) begin
          err_sticky <= 1'b1;
          err_code   <= fault_code;
        end
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_code   <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: a behavioural model queues expected outputs per stimulus cycle,
// a monitor pops and compares them one cycle later.
module tb_ring_phase_monitor;

  localparam int N     = 4;
  localparam int PH_W  = 2;
  localparam int REV_W = 8;
  localparam int LOCKN = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     ring_q = '0;
  logic             ring_select = 1'b0;
  logic             err_clr = 1'b0;
  logic [PH_W-1:0]  phase;
  logic             phase_valid;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             err_sticky;
  logic [1:0]       err_code;
  logic             reload_req;

  always #5 clk = ~clk;

  ring_phase_monitor #(
    .N           (N),
    .PH_W        (PH_W),
    .REV_W       (REV_W),
    .LOCK_CYCLES (LOCKN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ring_q      (ring_q),
    .ring_select (ring_select),
    .err_clr     (err_clr),
    .phase       (phase),
    .phase_valid (phase_valid),
    .rev_tick    (rev_tick),
    .rev_count   (rev_count),
    .err_sticky  (err_sticky),
    .err_code    (err_code),
    .reload_req  (reload_req)
  );

  typedef struct {
    int phase;
    int pv;
    int tick;
    int rev;
    int sticky;
    int code;
    int reload;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_popped = 0;

  // Model: m_run = -1 when not acquired, else count of consecutive good steps; tracking once it reaches LOCKN.
  int   m_run    = -1;
  bit   m_fault  = 0;
  int   m_prev   = 0;
  int   m_phase  = 0;
  int   m_rev    = 0;
  int   m_sticky = 0;
  int   m_code   = 0;

  function automatic int rot(input int p);
    return ((p * 2) % 16) + (p / 8);
  endfunction

  task automatic model_step(input bit r, input int q, input bit s, input bit c);
    exp_t e;
    bit   oh;
    bit   good;
    bit   tracking;
    int   tick;
    bit   fault;
    int   fcode;
    oh = ($countones(q) == 1);
    good = oh && (q == rot(m_prev));
    tracking = !m_fault && (m_run >= LOCKN);
    tick = 0;
    fault = 0;
    fcode = 0;
    if (!r) begin
      m_run = -1; m_fault = 0; m_prev = 0; m_phase = 0;
      m_rev = 0; m_sticky = 0; m_code = 0;
      e = '{0, 0, 0, 0, 0, 0, 0};
    end else begin
      if (m_fault) begin
        if (!s) begin m_fault = 0; m_run = -1; end
      end else if (m_run < 0) begin
        if (s && oh) m_run = 0;
      end else if (!tracking) begin
        if (s && good) m_run++;
        else m_run = -1;
      end else begin
        tick = (m_prev == 8 && q == 1) ? 1 : 0;
        if (!s) m_run = -1;
        else if (!good) begin fault = 1; fcode = oh ? 2 : 1; m_fault = 1; end
      end
      if (tick != 0) m_rev = (m_rev + 1) % 256;
      if (fault) begin
        if (m_sticky == 0 || c) begin m_sticky = 1; m_code = fcode; end
      end else if (c) begin
        m_sticky = 0; m_code = 0;
      end
      if (!m_fault && m_run >= LOCKN) m_phase = $clog2(q);
      e.phase  = m_phase;
      e.pv     = (!m_fault && m_run >= LOCKN) ? 1 : 0;
      e.tick   = tick;
      e.rev    = m_rev;
      e.sticky = m_sticky;
      e.code   = m_code;
      e.reload = m_fault ? 1 : 0;
    end
    m_prev = r ? q : 0;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic drive(input bit r, input int q, input bit s, input bit c);
    @(negedge clk);
    reset       = r;
    ring_q      = 4'(q);
    ring_select = s;
    err_clr     = c;
    model_step(r, q, s, c);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int req);
    n_checks++;
    if (act !== 32'(req)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_popped++;
        chk("phase",       32'(phase),       e.phase);
        chk("phase_valid", 32'(phase_valid), e.pv);
        chk("rev_tick",    32'(rev_tick),    e.tick);
        chk("rev_count",   32'(rev_count),   e.rev);
        chk("err_sticky",  32'(err_sticky),  e.sticky);
        chk("err_code",    32'(err_code),    e.code);
        chk("reload_req",  32'(reload_req),  e.reload);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int r;
    int k;
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    repeat (5) drive(1, 0, 1, 0);

    // Load, lock and track one revolution.
    drive(1, 1, 0, 0);
    drive(1, 2, 1, 0); drive(1, 4, 1, 0); drive(1, 8, 1, 0);
    drive(1, 1, 1, 0); drive(1, 2, 1, 0); drive(1, 4, 1, 0);

    // Not-one-hot fault, then reload back to IDLE.
    drive(1, 6, 1, 0); drive(1, 6, 1, 0); drive(1, 1, 0, 0);

    // Bad-step fault while sticky keeps code 01.
    drive(1, 2, 1, 0); drive(1, 4, 1, 0); drive(1, 8, 1, 0);
    drive(1, 1, 1, 0); drive(1, 2, 1, 0); drive(1, 8, 1, 0);
    drive(1, 1, 0, 1);

    // Bad-step fault, then err_clr coincident with a zero-ring fault.
    drive(1, 2, 1, 0); drive(1, 4, 1, 0); drive(1, 8, 1, 0);
    drive(1, 1, 1, 0); drive(1, 2, 1, 0); drive(1, 8, 1, 0);
    drive(1, 1, 0, 0);
    drive(1, 2, 1, 0); drive(1, 4, 1, 0); drive(1, 8, 1, 0); drive(1, 1, 1, 0);
    drive(1, 0, 1, 1);
    drive(1, 0, 1, 0);
    drive(1, 1, 0, 1);

    // 256 revolutions: rev_count wraps back to its starting value.
    drive(1, 2, 1, 0); drive(1, 4, 1, 0); drive(1, 8, 1, 0);
    for (int i = 0; i < 256 * 4; i++) drive(1, 1 << (i % 4), 1, 0);

    // Reset mid-TRACK at phase 2 with rev_count 5, then clean re-lock.
    drive(0, 0, 1, 0);
    drive(1, 1, 0, 0);
    drive(1, 2, 1, 0); drive(1, 4, 1, 0); drive(1, 8, 1, 0);
    for (int i = 0; i < 4 * 4 + 3; i++) drive(1, 1 << (i % 4), 1, 0);
    drive(0, 8, 1, 0);
    drive(1, 1, 1, 0); drive(1, 2, 1, 0); drive(1, 4, 1, 0); drive(1, 8, 1, 0);

    r = 8;
    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(0, 99));
      if (k < 1) begin
        drive(0, r, 1, 0);
      end else if (k < 6) begin
        r = 1 << $urandom_range(0, 3);
        drive(1, r, 0, 0);
      end else if (k < 10) begin
        r = int'($urandom_range(0, 15));
        drive(1, r, 1, bit'($urandom_range(0, 1)));
      end else if (k < 13) begin
        r = rot(rot(r));
        drive(1, r, 1, 0);
      end else begin
        r = rot(r);
        drive(1, r, 1, k < 16);
      end
    end

    drive(1, 1, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("outputs_seen", 32'(n_popped), n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
